// File: rtl/mvm_loader.sv
// Streams words from a valid/ready source into either the vector memory or the
// NUM_OLANES lane-interleaved matrix memories, one registered write per accepted word.
module mvm_loader #(
    parameter int DATAW      = 64,
    parameter int VEC_ADDRW  = 8,
    parameter int MAT_ADDRW  = 9,
    parameter int VEC_SIZEW  = VEC_ADDRW + 1,
    parameter int MAT_SIZEW  = MAT_ADDRW + 1,
    parameter int NUM_OLANES = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic                  dest_is_mat,
    input  logic [VEC_ADDRW-1:0]  vec_start_addr,
    input  logic [VEC_SIZEW-1:0]  vec_num_words,
    input  logic [MAT_ADDRW-1:0]  mat_start_addr,
    input  logic [MAT_SIZEW-1:0]  mat_num_rows_per_olane,
    input  logic                  ivalid,
    input  logic [DATAW-1:0]      idata,
    input  logic                  ilast,
    output logic                  iready,
    output logic                  vec_wen,
    output logic [VEC_ADDRW-1:0]  vec_waddr,
    output logic [NUM_OLANES-1:0] mat_wen,
    output logic [MAT_ADDRW-1:0]  mat_waddr,
    output logic [DATAW-1:0]      wdata,
    output logic                  busy,
    output logic                  done,
    output logic                  err
);

    localparam int LANEW = (NUM_OLANES > 1) ? $clog2(NUM_OLANES) : 1;
    localparam int TOTW  = VEC_SIZEW + MAT_SIZEW + LANEW;

    typedef enum logic {IDLE, LOAD} state_t;

    state_t                state;
    state_t                state_nxt;

    logic                  cmd_mat;
    logic [VEC_ADDRW-1:0]  cmd_vbase;
    logic [VEC_SIZEW-1:0]  cmd_nwords;
    logic [TOTW-1:0]       left;
    logic [VEC_SIZEW-1:0]  col;
    logic [LANEW-1:0]      lane;
    logic [MAT_ADDRW-1:0]  row_base;
    logic                  fin_p1;

    logic                  start_ok;
    logic                  accept;
    logic                  last_word;
    logic                  zero_len;
    logic [TOTW-1:0]       total_cmd;
    logic [NUM_OLANES-1:0] lane_onehot;

    assign iready    = (state == LOAD);
    assign start_ok  = start && (state == IDLE);
    assign accept    = ivalid && (state == LOAD);
    assign last_word = (left == TOTW'(1));
    // Full-width product so the largest matrix command cannot wrap the word count.
    assign total_cmd = dest_is_mat
                     ? TOTW'(vec_num_words) * TOTW'(mat_num_rows_per_olane) * TOTW'(NUM_OLANES)
                     : TOTW'(vec_num_words);
    assign zero_len  = (total_cmd == '0);

    always_comb begin
        lane_onehot       = '0;
        lane_onehot[lane] = 1'b1;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start_ok && !zero_len) state_nxt = LOAD;
            LOAD:    if (accept && last_word)   state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            cmd_mat    <= 1'b0;
            cmd_vbase  <= '0;
            cmd_nwords <= '0;
            left       <= '0;
            col        <= '0;
            lane       <= '0;
            row_base   <= '0;
            fin_p1     <= 1'b0;
            vec_wen    <= 1'b0;
            mat_wen    <= '0;
            vec_waddr  <= '0;
            mat_waddr  <= '0;
            wdata      <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            err        <= 1'b0;
        end else begin
            state   <= state_nxt;

            // Write stage: strobe, address and data one cycle after acceptance.
            vec_wen <= accept && !cmd_mat;
            mat_wen <= (accept && cmd_mat) ? lane_onehot : '0;
            if (accept) begin
                vec_waddr <= cmd_vbase + VEC_ADDRW'(col);
                mat_waddr <= row_base + MAT_ADDRW'(col);
                wdata     <= idata;
            end

            // Completion: fin_p1 marks the final strobe (or the lone busy cycle of an empty command).
            busy   <= start_ok || (state_nxt == LOAD) || accept;
            fin_p1 <= (accept && last_word) || (start_ok && zero_len);
            done   <= fin_p1;

            if (start_ok)
                err <= 1'b0;
            else if (accept && (ilast != last_word))
                err <= 1'b1;

            if (start_ok) begin
                cmd_mat    <= dest_is_mat;
                cmd_vbase  <= vec_start_addr;
                cmd_nwords <= vec_num_words;
                left       <= total_cmd;
                col        <= '0;
                lane       <= '0;
                row_base   <= mat_start_addr;
            end else if (accept) begin
                left <= left - TOTW'(1);
                if (col == cmd_nwords - VEC_SIZEW'(1)) begin
                    col <= '0;
                    if (lane == LANEW'(NUM_OLANES - 1)) begin
                        lane     <= '0;
                        row_base <= row_base + MAT_ADDRW'(cmd_nwords);
                    end else begin
                        lane <= lane + LANEW'(1);
                    end
                end else begin
                    col <= col + VEC_SIZEW'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_mvm_loader.sv
// Directed bench for mvm_loader: vector wrap, lane-interleaved matrix load, gaps,
// ilast errors, empty commands, mid-transfer reset and back-to-back starts.
module tb_mvm_loader;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic        dest_is_mat = 1'b0;
    logic [7:0]  vec_start_addr = '0;
    logic [8:0]  vec_num_words = '0;
    logic [8:0]  mat_start_addr = '0;
    logic [9:0]  mat_num_rows_per_olane = '0;
    logic        ivalid = 1'b0;
    logic [63:0] idata = '0;
    logic        ilast = 1'b0;
    logic        iready;
    logic        vec_wen;
    logic [7:0]  vec_waddr;
    logic [3:0]  mat_wen;
    logic [8:0]  mat_waddr;
    logic [63:0] wdata;
    logic        busy;
    logic        done;
    logic        err;

    mvm_loader dut (
        .clk(clk), .rst(rst), .start(start), .dest_is_mat(dest_is_mat),
        .vec_start_addr(vec_start_addr), .vec_num_words(vec_num_words),
        .mat_start_addr(mat_start_addr), .mat_num_rows_per_olane(mat_num_rows_per_olane),
        .ivalid(ivalid), .idata(idata), .ilast(ilast), .iready(iready),
        .vec_wen(vec_wen), .vec_waddr(vec_waddr), .mat_wen(mat_wen), .mat_waddr(mat_waddr),
        .wdata(wdata), .busy(busy), .done(done), .err(err)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int          s_cyc[$];
    logic        s_vec[$];
    logic [3:0]  s_lane[$];
    logic [7:0]  s_vaddr[$];
    logic [8:0]  s_maddr[$];
    logic [63:0] s_data[$];
    logic        s_busy[$];
    int          d_cyc[$];
    int          acc_q[$];
    logic        iready_seen = 1'b0;

    // Capture every write strobe and done pulse mid-cycle.
    always @(negedge clk) begin
        if (vec_wen || (mat_wen != 4'd0)) begin
            s_cyc.push_back(cyc);
            s_vec.push_back(vec_wen);
            s_lane.push_back(mat_wen);
            s_vaddr.push_back(vec_waddr);
            s_maddr.push_back(mat_waddr);
            s_data.push_back(wdata);
            s_busy.push_back(busy);
        end
        if (done) d_cyc.push_back(cyc);
        if (iready) iready_seen = 1'b1;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic clr();
        s_cyc.delete(); s_vec.delete(); s_lane.delete(); s_vaddr.delete();
        s_maddr.delete(); s_data.delete(); s_busy.delete(); d_cyc.delete();
        acc_q.delete(); iready_seen = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin @(posedge clk); #1; end
    endtask

    task automatic do_start(input logic m, input logic [7:0] vb, input logic [8:0] nw,
                            input logic [8:0] mb, input logic [9:0] rows, output int sc);
        dest_is_mat = m; vec_start_addr = vb; vec_num_words = nw;
        mat_start_addr = mb; mat_num_rows_per_olane = rows;
        start = 1'b1; sc = cyc;
        @(posedge clk); #1;
        start = 1'b0;
        // Scramble command inputs; the loader must use its registered copy.
        dest_is_mat = ~m; vec_start_addr = 8'h5A; vec_num_words = 9'd77;
        mat_start_addr = 9'h1A5; mat_num_rows_per_olane = 10'd9;
    endtask

    task automatic send(input logic [63:0] d, input logic l);
        int n;
        n = 0; idata = d; ilast = l; ivalid = 1'b1;
        while (iready !== 1'b1 && n < 20) begin @(posedge clk); #1; n++; end
        acc_q.push_back((iready === 1'b1) ? cyc : -100);
        @(posedge clk); #1;
        ivalid = 1'b0; ilast = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        idle(3);
        n_cmp++; if ({iready, vec_wen, mat_wen, busy, done, err} !== 9'd0) begin
            n_bad++; $display("FAIL reset_ctrl got %b want 0", {iready, vec_wen, mat_wen, busy, done, err}); end
        n_cmp++; if ({vec_waddr, mat_waddr} !== 17'd0) begin
            n_bad++; $display("FAIL reset_addr got %h want 0", {vec_waddr, mat_waddr}); end
        n_cmp++; if (wdata !== 64'd0) begin
            n_bad++; $display("FAIL reset_wdata got %h want 0", wdata); end
        rst = 1'b0;
        idle(1);
    endtask

    task automatic test_vector_wrap();
        int sc;
        logic [7:0] exp_a [8] = '{8'd250, 8'd251, 8'd252, 8'd253, 8'd254, 8'd255, 8'd0, 8'd1};
        clr();
        do_start(1'b0, 8'd250, 9'd8, 9'd0, 10'd0, sc);
        n_cmp++; if (busy !== 1'b1) begin n_bad++; $display("FAIL vec_busy_after_start got %b want 1", busy); end
        for (int k = 0; k < 8; k++) send(64'hA000 + 64'(k), k == 7);
        idle(4);
        n_cmp++; if (s_cyc.size() != 8) begin n_bad++; $display("FAIL vec_strobes got %0d want 8", s_cyc.size()); end
        for (int k = 0; k < 8 && k < s_cyc.size(); k++) begin
            n_cmp++; if (s_vaddr[k] !== exp_a[k] || s_vec[k] !== 1'b1 || s_lane[k] !== 4'd0) begin
                n_bad++; $display("FAIL vec_addr[%0d] got %0d/%b/%b want %0d/1/0000", k, s_vaddr[k], s_vec[k], s_lane[k], exp_a[k]); end
            n_cmp++; if (s_data[k] !== 64'hA000 + 64'(k) || s_cyc[k] !== acc_q[k] + 1) begin
                n_bad++; $display("FAIL vec_data[%0d] got %h@%0d want %h@%0d", k, s_data[k], s_cyc[k], 64'hA000 + 64'(k), acc_q[k] + 1); end
        end
        n_cmp++; if (s_busy.size() != 8 || s_busy[7] !== 1'b1) begin n_bad++; $display("FAIL vec_busy_last got %0d entries want busy=1 at last strobe", s_busy.size()); end
        n_cmp++; if (d_cyc.size() != 1 || d_cyc[0] !== acc_q[7] + 2) begin
            n_bad++; $display("FAIL vec_done got %0d pulses want 1 at %0d", d_cyc.size(), acc_q[7] + 2); end
        n_cmp++; if (err !== 1'b0 || busy !== 1'b0) begin n_bad++; $display("FAIL vec_err_busy got %b%b want 00", err, busy); end
    endtask

    task automatic test_matrix();
        int sc, r;
        logic [3:0] el;
        logic [8:0] ea;
        clr();
        do_start(1'b1, 8'd0, 9'd3, 9'd10, 10'd2, sc);
        for (int k = 0; k < 24; k++) send(64'hB00 + 64'(k), k == 23);
        idle(4);
        n_cmp++; if (s_cyc.size() != 24) begin n_bad++; $display("FAIL mat_strobes got %0d want 24", s_cyc.size()); end
        for (int k = 0; k < 24 && k < s_cyc.size(); k++) begin
            r  = k / 3;
            el = 4'd1 << (r % 4);
            ea = 9'(10 + (r / 4) * 3 + (k % 3));
            n_cmp++; if (s_lane[k] !== el || s_maddr[k] !== ea || s_vec[k] !== 1'b0 || s_data[k] !== 64'hB00 + 64'(k)) begin
                n_bad++; $display("FAIL mat_word[%0d] got lane %b addr %0d vec %b data %h want lane %b addr %0d vec 0 data %h",
                                  k, s_lane[k], s_maddr[k], s_vec[k], s_data[k], el, ea, 64'hB00 + 64'(k)); end
        end
        n_cmp++; if (s_maddr.size() > 14 && {s_lane[12], s_maddr[12], s_maddr[13], s_maddr[14]} !== {4'b0001, 9'd13, 9'd14, 9'd15}) begin
            n_bad++; $display("FAIL mat_row4 got lane %b addrs %0d %0d %0d want 0001 13 14 15", s_lane[12], s_maddr[12], s_maddr[13], s_maddr[14]); end
        n_cmp++; if (d_cyc.size() != 1 || err !== 1'b0) begin n_bad++; $display("FAIL mat_done got %0d pulses err %b want 1 pulse err 0", d_cyc.size(), err); end
    endtask

    task automatic test_gaps();
        int sc;
        clr();
        do_start(1'b0, 8'd20, 9'd4, 9'd0, 10'd0, sc);
        for (int k = 0; k < 4; k++) begin
            send(64'hC0 + 64'(k), k == 3);
            if (k < 3) begin
                idle(1);
                n_cmp++; if (busy !== 1'b1) begin n_bad++; $display("FAIL gap_busy[%0d] got %b want 1", k, busy); end
            end
        end
        idle(4);
        n_cmp++; if (s_cyc.size() != 4) begin n_bad++; $display("FAIL gap_strobes got %0d want 4", s_cyc.size()); end
        for (int k = 0; k < 4 && k < s_cyc.size(); k++) begin
            n_cmp++; if (s_cyc[k] !== acc_q[k] + 1 || s_vaddr[k] !== 8'(20 + k)) begin
                n_bad++; $display("FAIL gap_strobe[%0d] got addr %0d@%0d want %0d@%0d", k, s_vaddr[k], s_cyc[k], 20 + k, acc_q[k] + 1); end
        end
        n_cmp++; if (d_cyc.size() != 1) begin n_bad++; $display("FAIL gap_done got %0d want 1", d_cyc.size()); end
    endtask

    task automatic test_ilast_err();
        int sc;
        clr();
        do_start(1'b0, 8'd60, 9'd5, 9'd0, 10'd0, sc);
        for (int k = 0; k < 5; k++) begin
            send(64'hD0 + 64'(k), k == 2);
            if (k == 1) begin
                n_cmp++; if (err !== 1'b0) begin n_bad++; $display("FAIL err_before got %b want 0", err); end
            end
            if (k == 2) begin
                n_cmp++; if (err !== 1'b1) begin n_bad++; $display("FAIL err_after_early_last got %b want 1", err); end
            end
        end
        idle(4);
        n_cmp++; if (s_cyc.size() != 5 || d_cyc.size() != 1 || err !== 1'b1) begin
            n_bad++; $display("FAIL err_transfer got %0d strobes %0d done err %b want 5 1 1", s_cyc.size(), d_cyc.size(), err); end
        do_start(1'b0, 8'd0, 9'd1, 9'd0, 10'd0, sc);
        n_cmp++; if (err !== 1'b0) begin n_bad++; $display("FAIL err_clear got %b want 0", err); end
        send(64'hE0, 1'b1);
        idle(4);
    endtask

    task automatic test_zero_len();
        int sc;
        for (int m = 0; m < 2; m++) begin
            clr();
            do_start(m[0], 8'd3, (m == 0) ? 9'd0 : 9'd3, 9'd4, 10'd0, sc);
            n_cmp++; if (busy !== 1'b1 || done !== 1'b0) begin n_bad++; $display("FAIL zero_busy[%0d] got %b%b want 10", m, busy, done); end
            idle(4);
            n_cmp++; if (s_cyc.size() != 0 || iready_seen !== 1'b0) begin
                n_bad++; $display("FAIL zero_writes[%0d] got %0d strobes iready_seen %b want 0 0", m, s_cyc.size(), iready_seen); end
            n_cmp++; if (d_cyc.size() != 1 || d_cyc[0] !== sc + 2) begin
                n_bad++; $display("FAIL zero_done[%0d] got %0d pulses want 1 at %0d", m, d_cyc.size(), sc + 2); end
            n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL zero_idle[%0d] got busy %b want 0", m, busy); end
        end
    endtask

    task automatic test_reset_mid();
        int sc;
        clr();
        do_start(1'b0, 8'd100, 9'd8, 9'd0, 10'd0, sc);
        for (int k = 0; k < 3; k++) send(64'hF0 + 64'(k), 1'b0);
        rst = 1'b1; ivalid = 1'b1; idata = 64'hDEAD;
        idle(1);
        rst = 1'b0;
        idle(4);
        n_cmp++; if (iready !== 1'b0 || busy !== 1'b0) begin n_bad++; $display("FAIL rstmid_idle got iready %b busy %b want 0 0", iready, busy); end
        ivalid = 1'b0;
        n_cmp++; if (s_cyc.size() != 3 || d_cyc.size() != 0) begin
            n_bad++; $display("FAIL rstmid_abandon got %0d strobes %0d done want 3 0", s_cyc.size(), d_cyc.size()); end
        clr();
        do_start(1'b0, 8'd0, 9'd2, 9'd0, 10'd0, sc);
        send(64'h11, 1'b0);
        send(64'h22, 1'b1);
        idle(4);
        n_cmp++; if (s_cyc.size() != 2 || d_cyc.size() != 1 || s_vaddr[1] !== 8'd1 || s_data[1] !== 64'h22) begin
            n_bad++; $display("FAIL rstmid_fresh got %0d strobes %0d done want 2 1", s_cyc.size(), d_cyc.size()); end
    endtask

    task automatic test_back_to_back();
        int sc;
        clr();
        do_start(1'b0, 8'd5, 9'd2, 9'd0, 10'd0, sc);
        send(64'h501, 1'b0);
        // Final word (ilast missing) accepted together with a start that must be ignored.
        idata = 64'h502; ilast = 1'b0; ivalid = 1'b1;
        dest_is_mat = 1'b0; vec_start_addr = 8'd100; vec_num_words = 9'd1; start = 1'b1;
        n_cmp++; if (iready !== 1'b1) begin n_bad++; $display("FAIL b2b_ready got %b want 1", iready); end
        idle(1);
        start = 1'b0; ivalid = 1'b0;
        n_cmp++; if (iready !== 1'b0 || err !== 1'b1) begin n_bad++; $display("FAIL b2b_ignored got iready %b err %b want 0 1", iready, err); end
        idle(1);
        n_cmp++; if (done !== 1'b1) begin n_bad++; $display("FAIL b2b_done got %b want 1", done); end
        dest_is_mat = 1'b0; vec_start_addr = 8'd40; vec_num_words = 9'd1; start = 1'b1;
        idle(1);
        start = 1'b0;
        n_cmp++; if (iready !== 1'b1 || busy !== 1'b1 || err !== 1'b0) begin
            n_bad++; $display("FAIL b2b_restart got iready %b busy %b err %b want 1 1 0", iready, busy, err); end
        send(64'h503, 1'b1);
        idle(4);
        n_cmp++; if (s_cyc.size() != 3 || s_vaddr[0] !== 8'd5 || s_vaddr[1] !== 8'd6 || s_vaddr[2] !== 8'd40) begin
            n_bad++; $display("FAIL b2b_addrs got %0d strobes %0d %0d %0d want 3 strobes 5 6 40", s_cyc.size(), s_vaddr[0], s_vaddr[1], s_vaddr[2]); end
        n_cmp++; if (d_cyc.size() != 2) begin n_bad++; $display("FAIL b2b_done_count got %0d want 2", d_cyc.size()); end
    endtask

    initial begin
        test_reset();
        test_vector_wrap();
        test_matrix();
        test_gaps();
        test_ilast_err();
        test_zero_len();
        test_reset_mid();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/mvm_loader.md
MVM_LOADER -- requirements
Module: mvm_loader

Interface
REQ-001 Parameters SHALL be: DATAW, 64, word width; VEC_ADDRW, 8, vector memory address width; MAT_ADDRW, 9, matrix memory address width; VEC_SIZEW, VEC_ADDRW+1, vector size width; MAT_SIZEW, MAT_ADDRW+1, rows-per-lane width; NUM_OLANES, 4, output lanes (power of two).
REQ-002 Ports SHALL be, in order:
- clk  in  1  sole clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  command strobe, sampled only in IDLE.
- dest_is_mat  in  1  0 = load vector memory, 1 = load matrix memories.
- vec_start_addr  in  VEC_ADDRW  vector base address.
- vec_num_words  in  VEC_SIZEW  words per vector / per matrix row.
- mat_start_addr  in  MAT_ADDRW  matrix base address (same in every lane).
- mat_num_rows_per_olane  in  MAT_SIZEW  rows held by each lane.
- ivalid  in  1  input word valid.
- idata  in  DATAW  input word.
- ilast  in  1  producer's end-of-transfer marker.
- iready  out  1  loader accepts a word this cycle.
- vec_wen  out  1  vector memory write strobe.
- vec_waddr  out  VEC_ADDRW  vector write address.
- mat_wen  out  NUM_OLANES  one-hot per-lane matrix write strobe.
- mat_waddr  out  MAT_ADDRW  matrix write address.
- wdata  out  DATAW  write data, shared by both memories.
- busy  out  1  command in progress.
- done  out  1  one-cycle completion pulse.
- err  out  1  sticky ilast-mismatch flag.

Function
REQ-003 FSM SHALL have states IDLE and LOAD; IDLE->LOAD on start; LOAD->IDLE on the cycle the final word is accepted; start outside IDLE SHALL be ignored.
REQ-004 On start in IDLE, all command inputs SHALL be registered; later changes to them SHALL not affect the command.
REQ-005 Total words SHALL be vec_num_words (vector) or vec_num_words*mat_num_rows_per_olane*NUM_OLANES (matrix), computed without overflow.
REQ-006 iready SHALL be 1 exactly when state is LOAD; a word is accepted when ivalid && iready.
REQ-007 Every accepted word SHALL produce exactly one write strobe, with address and wdata, on the next cycle (1-cycle registered latency); no strobe otherwise.
REQ-008 Vector mode: word k SHALL write vec_waddr = vec_start_addr+k, modulo 2^VEC_ADDRW; mat_wen SHALL stay 0.
REQ-009 Matrix mode: word k with row r = k / vec_num_words and column c = k % vec_num_words SHALL assert mat_wen bit (r % NUM_OLANES) at mat_waddr = mat_start_addr + (r / NUM_OLANES)*vec_num_words + c, modulo 2^MAT_ADDRW; vec_wen SHALL stay 0.
REQ-010 The row/column/lane indices SHALL be tracked by counters (no divider): column counter wraps at vec_num_words, then the lane advances; after lane NUM_OLANES-1 the lane returns to 0 and the row base advances by vec_num_words.
REQ-011 busy SHALL be 1 from the cycle after start through the cycle of the final write strobe, inclusive.
REQ-012 done SHALL pulse for one cycle, on the cycle after the final write strobe.
REQ-013 err SHALL set when an accepted word has ilast=1 and is not the final word, or the final word has ilast=0; err SHALL hold until the next accepted start, which clears it; the transfer length SHALL still be governed by the count, not ilast.
REQ-014 Zero-length command (vec_num_words=0, or mat_num_rows_per_olane=0 in matrix mode) SHALL issue no writes, keep iready 0, hold busy 1 for one cycle, and pulse done on the following cycle.
REQ-015 ivalid gaps during LOAD SHALL stall the counters with no strobes and no state change.
REQ-016 start with the final-word acceptance in the same cycle SHALL be ignored (the FSM is not in IDLE); a start in the cycle done pulses SHALL be honoured.

Reset
REQ-017 When rst is 1, state SHALL go to IDLE and all counters SHALL clear.
REQ-018 Reset SHALL set iready, vec_wen, mat_wen, busy, done, and err to 0, and vec_waddr, mat_waddr, and wdata to 0.
REQ-019 Reset during LOAD SHALL abandon the transfer with no further strobes and no done pulse.

Verification
REQ-020 Vector load with vec_start_addr=250, vec_num_words=8, ilast on word 7 -> vec_waddr sequence 250..255,0,1; done pulses once; err stays 0.
REQ-021 Matrix load with vec_num_words=3, rows/lane=2, NUM_OLANES=4, mat_start_addr=10, 24 words -> lane order 0,1,2,3,0,1,2,3 per row; row 4 writes lane 0 at addresses 13,14,15.
REQ-022 Vector load of 4 words with ivalid toggling 1,0,1,0... -> exactly 4 strobes, each one cycle after its accept; busy stays 1 across the gaps.
REQ-023 Vector load of 5 words with ilast on word 2 -> err=1 from the cycle after the accept; all 5 words written; err cleared by the next start.
REQ-024 Zero-length command -> no strobes, iready never 1, done pulses two cycles after start.
REQ-025 Reset asserted after 3 of 8 words -> no further strobes, no done; a fresh command after reset completes normally.
